// File: rtl/exe_stage.sv
// Execute stage: ID/EX register, Val2 generator, ALU, NZCV status register and branch resolution.
// Optional operand forwarding muxes are enabled by defining EXE_FORWARD_EN.
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef EXE_FORWARD_EN
  input  logic [1:0]       sel_src1,
  input  logic [1:0]       sel_src2,
  input  logic [WIDTH-1:0] mem_fwd_val,
  input  logic [WIDTH-1:0] wb_fwd_val,
`endif
  input  logic             freeze,
  input  logic             flush,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] val_rn_in,
  input  logic [WIDTH-1:0] val_rm_in,
  input  logic             imm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm24_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             wb_en_in,
  input  logic             s_in,
  input  logic             b_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] st_val,
  output logic [3:0]       dest,
  output logic             wb_en,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_address,
  output logic [3:0]       status,
  output logic [3:0]       src1,
  output logic [3:0]       src2
);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] val_rn;
    logic [WIDTH-1:0] val_rm;
    logic             imm;
    logic [11:0]      so;
    logic [23:0]      imm24;
    logic [3:0]       exe_cmd;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             wb_en;
    logic             s;
    logic             b;
    logic [3:0]       dest;
    logic [3:0]       src1;
    logic [3:0]       src2;
  } idex_t;

  idex_t            idex_q, idex_d;
  logic [3:0]       status_q, status_d;
  logic [WIDTH-1:0] rn, rm, val2, alu_res;
  logic [WIDTH:0]   sum;
  logic [4:0]       sh_amt;
  logic [3:0]       flags;
  logic             c_f, v_f, upd;

  function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input logic [4:0] a);
    return (x >> a) | (x << (WIDTH - int'(a)));
  endfunction

  // Flush wins over freeze: a bubble is loaded even while the stage is stalled.
  always_comb begin
    idex_d = idex_q;
    if (flush || !freeze) begin
      idex_d.pc       = pc_in;
      idex_d.val_rn   = val_rn_in;
      idex_d.val_rm   = val_rm_in;
      idex_d.imm      = imm_in;
      idex_d.so       = shift_operand_in;
      idex_d.imm24    = signed_imm24_in;
      idex_d.exe_cmd  = exe_cmd_in;
      idex_d.mem_r_en = mem_r_en_in;
      idex_d.mem_w_en = mem_w_en_in;
      idex_d.wb_en    = wb_en_in;
      idex_d.s        = s_in;
      idex_d.b        = b_in;
      idex_d.dest     = dest_in;
      idex_d.src1     = src1_in;
      idex_d.src2     = src2_in;
      if (flush) begin
        idex_d.exe_cmd  = 4'b0000;
        idex_d.mem_r_en = 1'b0;
        idex_d.mem_w_en = 1'b0;
        idex_d.wb_en    = 1'b0;
        idex_d.s        = 1'b0;
        idex_d.b        = 1'b0;
      end
    end
  end

`ifdef EXE_FORWARD_EN
  always_comb begin
    case (sel_src1)
      2'b01:   rn = mem_fwd_val;
      2'b10:   rn = wb_fwd_val;
      default: rn = idex_q.val_rn;
    endcase
    case (sel_src2)
      2'b01:   rm = mem_fwd_val;
      2'b10:   rm = wb_fwd_val;
      default: rm = idex_q.val_rm;
    endcase
  end
`else
  assign rn = idex_q.val_rn;
  assign rm = idex_q.val_rm;
`endif

  // Register-specified shifts are not supported, so so[4]=1 degenerates to no shift.
  always_comb begin
    sh_amt = idex_q.so[4] ? 5'd0 : idex_q.so[11:7];
    val2   = rm;
    if (idex_q.imm) begin
      val2 = ror({{(WIDTH-8){1'b0}}, idex_q.so[7:0]}, {idex_q.so[11:8], 1'b0});
    end else if (idex_q.mem_r_en || idex_q.mem_w_en) begin
      val2 = {{(WIDTH-12){1'b0}}, idex_q.so};
    end else begin
      case (idex_q.so[6:5])
        2'b00:   val2 = rm << sh_amt;
        2'b01:   val2 = rm >> sh_amt;
        2'b10:   val2 = $unsigned($signed(rm) >>> sh_amt);
        default: val2 = ror(rm, sh_amt);
      endcase
    end
  end

  // Subtraction is Rn + ~Val2 + carry_in, so carry out directly means "no borrow".
  always_comb begin
    alu_res = '0;
    sum     = '0;
    c_f     = status_q[1];
    v_f     = status_q[0];
    upd     = 1'b1;
    case (idex_q.exe_cmd)
      4'b0001: alu_res = val2;
      4'b1001: alu_res = ~val2;
      4'b0010, 4'b0011: begin
        sum     = {1'b0, rn} + {1'b0, val2}
                + {{WIDTH{1'b0}}, (idex_q.exe_cmd[0] & status_q[1])};
        alu_res = sum[WIDTH-1:0];
        c_f     = sum[WIDTH];
        v_f     = (rn[WIDTH-1] == val2[WIDTH-1]) && (alu_res[WIDTH-1] != rn[WIDTH-1]);
      end
      4'b0100, 4'b0101: begin
        sum     = {1'b0, rn} + {1'b0, ~val2}
                + {{WIDTH{1'b0}}, (idex_q.exe_cmd[0] ? status_q[1] : 1'b1)};
        alu_res = sum[WIDTH-1:0];
        c_f     = sum[WIDTH];
        v_f     = (rn[WIDTH-1] != val2[WIDTH-1]) && (alu_res[WIDTH-1] != rn[WIDTH-1]);
      end
      4'b0110: alu_res = rn & val2;
      4'b0111: alu_res = rn | val2;
      4'b1000: alu_res = rn ^ val2;
      default: upd = 1'b0;
    endcase
    flags    = upd ? {alu_res[WIDTH-1], (alu_res == '0), c_f, v_f} : status_q;
    status_d = idex_q.s ? flags : status_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q   <= '0;
      status_q <= '0;
    end else begin
      idex_q   <= idex_d;
      status_q <= status_d;
    end
  end

  assign alu_result     = alu_res;
  assign st_val         = rm;
  assign dest           = idex_q.dest;
  assign wb_en          = idex_q.wb_en;
  assign mem_r_en       = idex_q.mem_r_en;
  assign mem_w_en       = idex_q.mem_w_en;
  assign branch_taken   = idex_q.b;
  assign branch_address = idex_q.pc + {{(WIDTH-26){idex_q.imm24[23]}}, idex_q.imm24, 2'b00};
  assign status         = status_q;
  assign src1           = idex_q.src1;
  assign src2           = idex_q.src2;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: expected ALU results go through a scoreboard queue,
// control/status outputs are compared against constants at each step.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, flush;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm24_in;
  logic [3:0]  exe_cmd_in;
  logic        mem_r_en_in, mem_w_en_in, wb_en_in, s_in, b_in;
  logic [3:0]  dest_in, src1_in, src2_in;
  logic [31:0] alu_result, st_val, branch_address;
  logic [3:0]  dest, status, src1, src2;
  logic        wb_en, mem_r_en, mem_w_en, branch_taken;

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
`ifdef EXE_FORWARD_EN
    .sel_src1(2'b00), .sel_src2(2'b00), .mem_fwd_val(32'h0), .wb_fwd_val(32'h0),
`endif
    .freeze(freeze), .flush(flush), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
    .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .wb_en_in(wb_en_in), .s_in(s_in), .b_in(b_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
    .alu_result(alu_result), .st_val(st_val), .dest(dest), .wb_en(wb_en),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .branch_taken(branch_taken),
    .branch_address(branch_address), .status(status), .src1(src1), .src2(src2)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    freeze = 0; flush = 0; pc_in = 0; val_rn_in = 0; val_rm_in = 0; imm_in = 0;
    shift_operand_in = 0; signed_imm24_in = 0; exe_cmd_in = 0;
    mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0; s_in = 0; b_in = 0;
    dest_in = 0; src1_in = 0; src2_in = 0;
  endtask

  task automatic alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                     input logic im, input logic [11:0] so, input logic s, input logic wb);
    exe_cmd_in = cmd; val_rn_in = rn; val_rm_in = rm; imm_in = im;
    shift_operand_in = so; s_in = s; wb_en_in = wb;
  endtask

  // Scoreboard: push the expected result, clock it in, pop and compare after the edge.
  task automatic issue(input string tag, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, alu_result, e);
  endtask

  initial begin
    // Reset with random inputs
    rst = 0;
    clear_in();
    val_rn_in = $urandom; val_rm_in = $urandom; pc_in = $urandom;
    exe_cmd_in = 4'($urandom_range(0, 15)); wb_en_in = 1; s_in = 1; b_in = 1;
    mem_r_en_in = 1; dest_in = 4'($urandom_range(1, 15));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu", alu_result, 32'h0);
    chk("rst_stval", st_val, 32'h0);
    chk("rst_dest", {28'h0, dest}, 32'h0);
    chk("rst_ctrl", {28'h0, wb_en, mem_r_en, mem_w_en, branch_taken}, 32'h0);
    chk("rst_status", {28'h0, status}, 32'h0);

    rst = 1;
    clear_in();
    issue("bubble_alu", 32'h0);
    chk("bubble_ctrl", {28'h0, wb_en, mem_r_en, mem_w_en, branch_taken}, 32'h0);

    // ADD with S: overflow into sign bit
    alu(4'b0010, 32'h7FFF_FFFF, 32'h0, 1, 12'h001, 1, 1);
    issue("add_ovf", 32'h8000_0000);
    chk("add_status_pre", {28'h0, status}, 32'h0);
    clear_in();
    issue("add_next", 32'h0);
    chk("add_status", {28'h0, status}, 32'h9);

    // CMP then SBC using the freshly written C
    alu(4'b0100, 32'd5, 32'h0, 1, 12'h005, 1, 0);
    issue("cmp", 32'h0);
    chk("cmp_wb", {31'h0, wb_en}, 32'h0);
    alu(4'b0101, 32'd10, 32'h0, 1, 12'h003, 0, 1);
    issue("sbc", 32'd7);
    chk("cmp_status", {28'h0, status}, 32'h6);

    // Val2 shifter and rotator
    alu(4'b0001, 32'h0, 32'h8000_0001, 0, 12'h0C3, 0, 1);
    issue("mov_asr", 32'hC000_0000);
    chk("stval", st_val, 32'h8000_0001);
    alu(4'b0001, 32'h0, 32'h0, 1, 12'h1FF, 0, 1);
    issue("mov_ror_imm", 32'hC000_003F);
    alu(4'b1001, 32'h0, 32'h0, 1, 12'h000, 0, 1);
    issue("mvn", 32'hFFFF_FFFF);
    alu(4'b0011, 32'd1, 32'h0, 1, 12'h001, 0, 1);
    issue("adc", 32'd3);
    alu(4'b0001, 32'h0, 32'h1234_5678, 0, 12'h210, 0, 1);
    issue("reg_shift_ignored", 32'h1234_5678);
    alu(4'b0001, 32'h0, 32'h8000_0001, 0, 12'h0E0, 0, 1);
    issue("mov_ror_reg", 32'hC000_0000);

    // Load address path uses 12-bit immediate
    alu(4'b0010, 32'h1000, 32'h0, 0, 12'hABC, 0, 1);
    mem_r_en_in = 1; dest_in = 4'd9;
    issue("ldr_addr", 32'h0000_1ABC);
    chk("ldr_ctrl", {23'h0, dest, wb_en, mem_r_en, mem_w_en, branch_taken}, {23'h0, 4'd9, 4'b1100});
    clear_in();

    // Logic ops with LSL #4 / LSR #4 operands
    alu(4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 12'h200, 0, 1);
    issue("and", 32'hF000_F000);
    alu(4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 12'h200, 0, 1);
    issue("orr", 32'hFFF0_FFF0);
    alu(4'b1000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 12'h220, 0, 1);
    issue("eor_lsr", 32'hF00F_F00F);

    // Undefined opcode with S: result 0, flags untouched
    alu(4'b1111, 32'hFFFF_FFFF, 32'h0, 1, 12'h001, 1, 1);
    issue("bad_op", 32'h0);
    clear_in();
    issue("bad_op_next", 32'h0);
    chk("bad_op_status", {28'h0, status}, 32'h6);

    // Branch, then a flushed instruction
    pc_in = 32'h100; signed_imm24_in = 24'hFFFFFE; b_in = 1;
    issue("br_alu", 32'h0);
    chk("br_taken", {31'h0, branch_taken}, 32'h1);
    chk("br_addr", branch_address, 32'h0000_00F8);
    clear_in();
    alu(4'b0010, 32'd1, 32'h0, 1, 12'h001, 1, 1);
    flush = 1;
    issue("flushed", 32'h0);
    chk("flushed_ctrl", {28'h0, wb_en, mem_r_en, mem_w_en, branch_taken}, 32'h0);
    clear_in();
    issue("flushed_next", 32'h0);
    chk("flushed_status", {28'h0, status}, 32'h6);

    // Freeze holds, freeze+flush loads a bubble
    alu(4'b0010, 32'd3, 32'h0, 1, 12'h004, 0, 1);
    dest_in = 4'd5;
    issue("frz_add", 32'd7);
    freeze = 1;
    alu(4'b0100, 32'd100, 32'h0, 1, 12'h001, 1, 0);
    dest_in = 4'd2;
    for (int i = 0; i < 3; i++) begin
      issue("frz_hold", 32'd7);
      chk("frz_dest", {27'h0, dest, wb_en}, {27'h0, 4'd5, 1'b1});
    end
    flush = 1;
    issue("frz_flush", 32'h0);
    chk("frz_flush_wb", {31'h0, wb_en}, 32'h0);
    clear_in();

    // Reset mid-cycle acts immediately
    alu(4'b0010, 32'd1, 32'h0, 1, 12'h001, 0, 1);
    issue("pre_reset", 32'd2);
    #3;
    rst = 0;
    #1;
    chk("async_alu", alu_result, 32'h0);
    chk("async_status", {28'h0, status}, 32'h0);
    chk("async_wb", {31'h0, wb_en}, 32'h0);
    #10;
    rst = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM pipeline: holds the ID/EX pipeline register, generates the second operand (Val2), runs the ALU, owns the NZCV status register and resolves branches. It consumes the decode stage's outputs and produces the ALU result, store data and control for the EX/MEM register. It also returns branch target and status flags upstream to IF and ID.

## Interface
Parameters:
- WIDTH, 32, datapath width (only 32 is supported)

Ports:
- clk  in  1  pipeline clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  hold ID/EX register contents (hazard stall)
- flush  in  1  load bubble into ID/EX register (driven by branch_taken)
- pc_in  in  32  PC+4 of the instruction in decode
- val_rn_in, val_rm_in  in  32 each  register-file read values
- imm_in  in  1  I bit
- shift_operand_in  in  12  instruction bits [11:0]
- signed_imm24_in  in  24  branch offset
- exe_cmd_in  in  4  ALU opcode
- mem_r_en_in, mem_w_en_in, wb_en_in, s_in, b_in  in  1 each  control bits
- dest_in, src1_in, src2_in  in  4 each  register indices
- alu_result  out  32  ALU output / memory address
- st_val  out  32  store data (Rm after forwarding)
- dest, wb_en, mem_r_en, mem_w_en  out  4/1/1/1  passed-through control
- branch_taken  out  1  branch resolved taken this cycle
- branch_address  out  32  branch target
- status  out  4  NZCV, {N,Z,C,V}
- src1, src2  out  4 each  registered source indices, for the hazard/forwarding unit

## Operation
- ID/EX register: on a rising clk with freeze=0, all *_in fields are captured. With flush=1, every control bit (wb_en, mem_r_en, mem_w_en, s, b) is cleared and exe_cmd is set to 0000; data fields are don't-care. flush has priority over freeze. With freeze=1 and flush=0, contents are held.
- Val2:
  - imm=1: {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - Otherwise, if mem_r_en or mem_w_en: {20'b0, so[11:0]}.
  - Otherwise: Rm shifted by so[11:7] with type so[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). Shift amount 0 passes Rm unchanged. so[4]=1 (register-specified shift) is unsupported and is treated as amount 0.
- ALU, selected by exe_cmd:
  - 0001 MOV = Val2; 1001 MVN = ~Val2
  - 0010 ADD = Rn+Val2; 0011 ADC = Rn+Val2+C
  - 0100 SUB = Rn-Val2; 0101 SBC = Rn-Val2-!C
  - 0110 AND; 0111 ORR; 1000 EOR
  - CMP uses 0100 and TST uses 0110, each with wb_en=0. LDR/STR use 0010.
  - Any other opcode: result 0, flags unchanged.
- Flags:
  - N = result[31]; Z = (result==0).
  - Add: C = carry out of bit 31. Subtract: C = 1 when there is no borrow. V = signed overflow.
  - Logic ops and MOV/MVN update N,Z only and leave C,V unchanged.
- Status register: at a rising clk, if registered s=1, NZCV is loaded from the ALU flags. The status port is the register output, consumed by ID's condition check.
- Branch: branch_taken = registered b. branch_address = pc + (sign-extend(signed_imm24) << 2), with 32-bit wrap-around.
- A bubble must never change status or assert branch_taken.

## Timing
- Reset (rst=0, asynchronous): the ID/EX register is cleared to a bubble and status=0000. Consequently alu_result=0, st_val=0, dest=0, and all control outputs and branch_taken are 0.
- Latency: inputs captured at edge N. alu_result, branch_taken and branch_address are combinational from the register and valid during cycle N to N+1.
- Status written at edge N+1 is visible to the instruction in ID starting at cycle N+1.
- Simultaneous freeze and flush: flush wins.
- Reset asserted mid-operation overrides everything immediately.
- ADC/SBC use the status C as registered before the current edge.

## Configuration
- EXE_FORWARD_EN defined: the block adds these inputs:
  - sel_src1, sel_src2 (2 bits each; 00 register, 01 MEM, 10 WB)
  - mem_fwd_val and wb_fwd_val (32 bits each)
  
  Rn and Rm are muxed after the ID/EX register and before Val2/ALU. st_val uses the forwarded Rm.
- EXE_FORWARD_EN undefined: these ports are absent and the registered Rn/Rm are used directly. Hazards are then handled only by freeze.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0, status=0000. Release rst and drive a bubble → outputs remain 0.
- ADD with S: Rn=0x7FFFFFFF, imm=1, so=0x001, cmd 0010, s=1 → alu_result=0x80000000. After the next edge, status=1001 (N=1, V=1).
- SUB/CMP: Rn=5, Val2=5, cmd 0100, s=1, wb_en=0 → result 0, status=0110. Then SBC with Rn=10, Val2=3 → result 7.
- Val2 shift/rotate:
  - Rm=0x80000001, so=0x0C3 (ASR #1) with MOV → 0xC0000000.
  - imm so=0x1FF (0xFF ROR 2) → 0xC000003F.
- Branch: pc_in=0x100, signed_imm24=0xFFFFFE, b=1 → branch_taken=1, branch_address=0xF8. With flush=1 on the next edge, the following instruction is captured as a bubble (wb_en=0, status unchanged).
- Freeze/flush: ADD captured; freeze=1 for 3 cycles → outputs held constant. freeze=1 with flush=1 → bubble loaded.
